// File: rtl/bias_fetch_seq.sv
// bias_fetch_seq: walks the N_BIAS entries of one bias-ROM layer and streams them out in order.
// Optional: define BIAS_FETCH_ERR_EN to reject out-of-range layer selects with an err pulse.
`ifndef BIT_LENGTH
`define BIT_LENGTH 16
`endif

module bias_fetch_seq #(
    parameter int BW      = `BIT_LENGTH,
    parameter int N_BIAS  = 24,
    parameter int N_LAYER = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    layer,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   rom_addr,
    input  logic [BW-1:0] rom_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [BW-1:0] b_data,
    output logic [4:0]    b_idx,
    output logic          b_last
);
    localparam int         DEPTH     = 4;
    localparam logic [1:0] MAX_LAYER = 2'(N_LAYER - 1);
    localparam logic [4:0] LAST_IDX  = 5'(N_BIAS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state;

    logic [4:0]    issue_cnt;
    logic          p1_v, p2_v;
    logic [4:0]    p1_idx, p2_idx;
    logic [BW-1:0] fifo_data [DEPTH];
    logic [4:0]    fifo_idx  [DEPTH];
    logic [1:0]    wr_ptr, rd_ptr;
    logic [2:0]    count;
    logic [3:0]    occupancy;

    logic          push, pop, can_issue, start_ok, start_bad;
    logic [1:0]    layer_eff;
    logic [15:0]   base_addr;

`ifdef BIAS_FETCH_ERR_EN
    assign start_bad = start && (state == IDLE) && (layer > MAX_LAYER);
    assign layer_eff = layer;
`else
    assign start_bad = 1'b0;
    assign layer_eff = (layer > MAX_LAYER) ? MAX_LAYER : layer;
`endif

    assign start_ok  = start && (state == IDLE) && !start_bad;
    assign base_addr = 16'(layer_eff) * 16'(N_BIAS);

    // Words already buffered plus reads still in the ROM pipe must fit the FIFO,
    // so an issued read always has a slot waiting for it.
    assign occupancy = {1'b0, count} + {3'b000, p1_v} + {3'b000, p2_v};
    assign can_issue = (occupancy < 4'(DEPTH));

    // Output stream: a beat transfers on a cycle where b_valid && b_ready; while
    // b_valid is high, b_data/b_idx/b_last hold steady until that transfer.
    assign b_valid = (count != 3'd0);
    assign b_data  = fifo_data[rd_ptr];
    assign b_idx   = fifo_idx[rd_ptr];
    assign b_last  = b_valid && (b_idx == LAST_IDX);
    assign push    = p2_v;
    assign pop     = b_valid && b_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rom_addr  <= 16'd0;
            issue_cnt <= 5'd0;
            p1_v      <= 1'b0;
            p2_v      <= 1'b0;
            p1_idx    <= 5'd0;
            p2_idx    <= 5'd0;
        end else begin
            done   <= 1'b0;
            err    <= start_bad;
            p2_v   <= p1_v;
            p2_idx <= p1_idx;
            p1_v   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        rom_addr  <= base_addr;
                        p1_v      <= 1'b1;
                        p1_idx    <= 5'd0;
                        issue_cnt <= 5'd1;
                        busy      <= 1'b1;
                        state     <= (N_BIAS == 1) ? DRAIN : FETCH;
                    end
                end
                FETCH: begin
                    if (can_issue) begin
                        rom_addr  <= rom_addr + 16'd1;
                        p1_v      <= 1'b1;
                        p1_idx    <= issue_cnt;
                        issue_cnt <= issue_cnt + 5'd1;
                        if (issue_cnt == LAST_IDX) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && b_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= 5'd0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rom_data;
                fifo_idx[wr_ptr]  <= p2_idx;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: doc/bias_fetch_seq.md
# bias_fetch_seq

Read-side sequencer for the per-core bias ROM: on a start pulse it walks the 24 bias entries of one selected mix layer, drives the ROM address port, absorbs the ROM's one-cycle registered read latency, and presents the biases as an in-order valid/ready stream to the accumulator datapath. One instance sits beside each bias ROM core, between it and the mix-layer MAC/add stage. A small credit-controlled FIFO keeps the stream at full rate under back-pressure.

## Interface
- `BW`, default `` `BIT_LENGTH `` (from num_data.v): bias word width.
- `N_BIAS`, default 24: biases per layer.
- `N_LAYER`, default 3: layers stored in the ROM; layer L occupies addresses L*N_BIAS .. L*N_BIAS+N_BIAS-1.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a layer fetch; honoured only in IDLE.
- `layer` in 2: layer select, sampled with `start`.
- `busy` out 1: high from accepted start until last beat handshakes.
- `done` out 1: one-cycle pulse, cycle after last beat handshakes.
- `err` out 1: one-cycle pulse on rejected start (see Configuration).
- `rom_addr` out 16: registered address to the ROM `addr` port.
- `rom_data` in BW: ROM `output_bias`, valid the cycle after `rom_addr`.
- `b_valid` out 1, `b_ready` in 1: output handshake; beat transfers when both high.
- `b_data` out BW: bias value.
- `b_idx` out 5: bias index 0..N_BIAS-1 within the layer.
- `b_last` out 1: high with the beat where `b_idx` = N_BIAS-1.

## Operation
- Reset values: `busy`,`done`,`err`,`b_valid`,`b_last` = 0; `rom_addr`,`b_data`,`b_idx` = 0; FSM IDLE; FIFO empty; counters 0.
- FSM: IDLE -> FETCH on accepted start; FETCH -> DRAIN when the N_BIAS-th address issued; DRAIN -> IDLE on handshake of the `b_last` beat.
- Accepted start: rom_addr loads layer*N_BIAS in the same edge (first issue); issue counter = 1.
- Issue pipeline: stage p1 (address in rom_addr), stage p2 (rom_data valid); p2 writes FIFO at next edge together with its index.
- FIFO depth 4; issue permitted only when FIFO count + in-flight (p1+p2) < 4 — FIFO never overflows, no data dropped.
- Issue address increments by 1 each issue; never leaves the selected layer range.
- `b_data`/`b_idx`/`b_last` driven from FIFO head; pop on `b_valid && b_ready`; simultaneous push and pop in one cycle allowed, count unchanged.
- `start` while busy ignored (no err). `layer`/`start` changes outside the accepted cycle have no effect.
- `rst` mid-fetch: immediate return to reset values; FIFO and in-flight reads discarded; ROM output after reset ignored.

## Timing
- Start high in cycle 0 -> rom_addr = base in cycle 1 -> rom_data in cycle 2 -> `b_valid` first beat in cycle 3.
- `b_ready` held high: one beat per cycle, beats in cycles 3..26 for N_BIAS=24; `busy` low from cycle 27; `done` high in cycle 27.
- `busy` falls at the edge of the last handshake; new start accepted in the `done` cycle.
- Back-pressure: with `b_ready` low, at most 4 words buffered, issue stalls; resumption costs no bubble while FIFO non-empty.

## Configuration
- `BIAS_FETCH_ERR_EN` defined: start with `layer` ≥ N_LAYER is rejected, FSM stays IDLE, `err` pulses one cycle in the following cycle, `busy` stays 0.
- Undefined: `err` tied 0; `layer` ≥ N_LAYER is clamped to N_LAYER-1 and the fetch proceeds normally.

## Test plan
- ROM model mem[a] = 16'h0100+a, start layer=1, b_ready=1 -> 24 beats data 16'h0118..16'h012F, idx 0..23, b_last on last, first b_valid cycle 3, done cycle 27.
- Layer 2, b_ready toggling 1/0 every cycle -> same 24 values in order, no loss/duplication, rom_addr never beyond 71, FIFO count ≤ 4.
- b_ready low 20 cycles after start layer=0 -> exactly 4 beats buffered, rom_addr frozen at 3, then 24 correct beats once ready.
- start pulsed again mid-fetch with layer=2 -> ignored; stream continues layer 0 values 16'h0100..16'h0117.
- rst asserted at beat 10 of layer 1 -> all outputs 0 asynchronously; subsequent start layer=0 yields clean 16'h0100.. stream.
- start layer=3: with BIAS_FETCH_ERR_EN -> err pulse, busy 0, no beats; without -> layer-2 values 16'h0130..16'h0147.
